// File: rtl/skipdecode_if.sv
// Bundle of the skip-ring observation inputs and the decoded-mask outputs.
// The master side drives the ring signals, and the slave side is the decoder.
interface skipdecode_if #(
    parameter int LEN = 16
) ();
    logic                     E;
    logic                     B0;
    logic                     TOG;
    logic [LEN-1:0]           MASK;
    logic                     VALID;
    logic                     ERR;
    logic [$clog2(LEN)-1:0]   SLOT;

    modport master (output E, B0, TOG, input MASK, VALID, ERR, SLOT);
    modport slave  (input E, B0, TOG, output MASK, VALID, ERR, SLOT);
endinterface

// File: rtl/skipdecode.sv
// Rebuilds the rotating clock-skip mask from the delivered-pulse toggle.
// VALID asserts after LOCK identical consecutive frames.
module skipdecode #(
    parameter int LEN  = 16,
    parameter int LOCK = 3
) (
    input  logic         iCLK,
    input  logic         RST,
    skipdecode_if.slave  bus
);
    localparam int SW = $clog2(LEN);
    localparam int CW = $clog2(LOCK + 1);

    typedef enum logic [1:0] {HUNT, FILL, CHECK, LOCKED} state_t;

    state_t          r_state;
    state_t          w_stateNext;
    logic            r_togQ;
    logic [SW-1:0]   r_slot;
    logic [LEN-2:0]  r_cap;
    logic [LEN-1:0]  r_mask;
    logic            r_valid;
    logic            r_err;
    logic [CW-1:0]   r_cnt;

    logic [LEN-1:0]  w_maskNext;
    logic [CW-1:0]   w_cntNext;
    logic            w_validNext;
    logic            w_errNext;

    logic            w_present;
    logic            w_b0Slot;
    logic            w_badB0;
    logic            w_missB0;
    logic            w_frameEnd;
    logic [LEN-1:0]  w_word;
    logic            w_match;
    logic [CW-1:0]   w_cntInc;
    logic [SW-1:0]   w_capIdx;

    assign w_present  = bus.TOG ^ r_togQ;
    assign w_b0Slot   = bus.E & bus.B0;
    assign w_badB0    = w_b0Slot && (r_slot != '0) && (r_state != HUNT);
    assign w_missB0   = bus.E && !bus.B0 && (r_slot == '0) && (r_state != HUNT);
    // A B0 on the last slot is a framing error, so it never completes a frame.
    assign w_frameEnd = bus.E && !bus.B0 && (r_slot == SW'(LEN - 1));
    assign w_word     = {~w_present, r_cap};
    assign w_match    = (w_word == r_mask);
    assign w_cntInc   = r_cnt + 1'b1;
    assign w_capIdx   = bus.B0 ? '0 : r_slot;

    always_ff @(posedge iCLK) begin
        r_togQ <= bus.TOG;
    end

    always_ff @(posedge iCLK) begin
        if (RST) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        if (w_badB0) begin
            w_stateNext = FILL;
        end else if (w_missB0) begin
            w_stateNext = HUNT;
        end else begin
            unique case (r_state)
                HUNT:    if (w_b0Slot) w_stateNext = FILL;
                FILL:    if (w_frameEnd) w_stateNext = (LOCK == 1) ? LOCKED : CHECK;
                CHECK:   if (w_frameEnd && w_match && (w_cntInc == CW'(LOCK))) w_stateNext = LOCKED;
                LOCKED:  if (w_frameEnd && !w_match && (LOCK != 1)) w_stateNext = CHECK;
                default: w_stateNext = HUNT;
            endcase
        end
    end

    always_comb begin
        w_maskNext  = r_mask;
        w_cntNext   = r_cnt;
        w_validNext = r_valid;
        w_errNext   = 1'b0;
        // Framing errors win over any compare that would finish on the same slot.
        if (w_badB0 || w_missB0) begin
            w_errNext   = 1'b1;
            w_validNext = 1'b0;
        end else if (w_frameEnd) begin
            unique case (r_state)
                FILL: begin
                    w_maskNext  = w_word;
                    w_cntNext   = CW'(1);
                    w_validNext = (LOCK == 1);
                end
                CHECK: begin
                    if (w_match) begin
                        w_cntNext = w_cntInc;
                        if (w_cntInc == CW'(LOCK)) w_validNext = 1'b1;
                    end else begin
                        w_maskNext = w_word;
                        w_cntNext  = CW'(1);
                        w_errNext  = 1'b1;
                    end
                end
                LOCKED: begin
                    if (!w_match) begin
                        w_maskNext  = w_word;
                        w_cntNext   = CW'(1);
                        w_errNext   = 1'b1;
                        w_validNext = (LOCK == 1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge iCLK) begin
        if (RST) begin
            r_slot  <= '0;
            r_cap   <= '0;
            r_mask  <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_mask  <= w_maskNext;
            r_valid <= w_validNext;
            r_err   <= w_errNext;
            r_cnt   <= w_cntNext;
            if (bus.E) begin
                if (w_capIdx != SW'(LEN - 1)) r_cap[w_capIdx] <= ~w_present;
                if (bus.B0) begin
                    r_slot <= SW'(1);
                end else if (r_slot == SW'(LEN - 1)) begin
                    r_slot <= '0;
                end else begin
                    r_slot <= r_slot + 1'b1;
                end
            end
        end
    end

    assign bus.MASK  = r_mask;
    assign bus.VALID = r_valid;
    assign bus.ERR   = r_err;
    assign bus.SLOT  = r_slot;
endmodule

// File: tb/tb_skipdecode.sv
// Directed bench for skipdecode with LEN=16, LOCK=3.
// Each scenario task drives the ring and checks its own hand-computed results.
module tb_skipdecode;
    logic iCLK = 1'b0;
    logic RST  = 1'b1;
    int   compared   = 0;
    int   mismatched = 0;

    skipdecode_if #(.LEN(16)) bus ();
    skipdecode #(.LEN(16), .LOCK(3)) dut (.iCLK(iCLK), .RST(RST), .bus(bus));

    always #5 iCLK = ~iCLK;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // One ring cycle; a delivered pulse flips TOG during the slot it belongs to.
    task automatic driveSlot(input logic e, input logic b0, input logic pres);
        bus.E  = e;
        bus.B0 = b0;
        if (pres) bus.TOG = ~bus.TOG;
        @(posedge iCLK);
        #1;
    endtask

    task automatic runTracked(input logic [15:0] pat, input int startSlot, input int n,
                              output int riseAt, output int errs);
        int s;
        riseAt = -1;
        errs   = 0;
        for (int i = 0; i < n; i++) begin
            s = (startSlot + i) % 16;
            driveSlot(1'b1, s == 0, ~pat[s]);
            if (riseAt < 0 && bus.VALID === 1'b1) riseAt = i + 1;
            if (bus.ERR === 1'b1) errs++;
        end
    endtask

    task automatic test_reset;
        RST = 1'b1;
        driveSlot(1'b0, 1'b0, 1'b0);
        driveSlot(1'b0, 1'b0, 1'b0);
        compared++; if (bus.MASK !== 16'h0000) begin mismatched++; $display("[TB] FAIL reset_mask: got %h expected 0000", bus.MASK); end
        compared++; if (bus.VALID !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.VALID); end
        compared++; if (bus.ERR !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_err: got %b expected 0", bus.ERR); end
        compared++; if (bus.SLOT !== 4'd0) begin mismatched++; $display("[TB] FAIL reset_slot: got %0d expected 0", bus.SLOT); end
        RST = 1'b0;
    endtask

    task automatic test_lock;
        int rise, errs, hErrs;
        hErrs = 0;
        for (int i = 0; i < 3; i++) begin
            driveSlot(1'b1, 1'b0, 1'b1);
            if (bus.ERR === 1'b1) hErrs++;
        end
        compared++; if (bus.SLOT !== 4'd3) begin mismatched++; $display("[TB] FAIL hunt_slot: got %0d expected 3", bus.SLOT); end
        runTracked(16'h0005, 0, 16, rise, errs);
        compared++; if (bus.MASK !== 16'h0005) begin mismatched++; $display("[TB] FAIL fill_mask: got %h expected 0005", bus.MASK); end
        compared++; if (bus.VALID !== 1'b0) begin mismatched++; $display("[TB] FAIL fill_valid: got %b expected 0", bus.VALID); end
        hErrs += errs;
        runTracked(16'h0005, 0, 32, rise, errs);
        hErrs += errs;
        compared++; if (rise + 16 !== 48) begin mismatched++; $display("[TB] FAIL lock_latency: got %0d expected 48", rise + 16); end
        compared++; if (hErrs !== 0) begin mismatched++; $display("[TB] FAIL lock_err_count: got %0d expected 0", hErrs); end
        compared++; if (bus.MASK !== 16'h0005) begin mismatched++; $display("[TB] FAIL lock_mask: got %h expected 0005", bus.MASK); end
        compared++; if (bus.SLOT !== 4'd0) begin mismatched++; $display("[TB] FAIL lock_slot: got %0d expected 0", bus.SLOT); end
    endtask

    task automatic test_pattern_change;
        int rise, errs;
        runTracked(16'h8001, 0, 16, rise, errs);
        compared++; if (errs !== 1) begin mismatched++; $display("[TB] FAIL change_err_count: got %0d expected 1", errs); end
        compared++; if (bus.ERR !== 1'b1) begin mismatched++; $display("[TB] FAIL change_err: got %b expected 1", bus.ERR); end
        compared++; if (bus.VALID !== 1'b0) begin mismatched++; $display("[TB] FAIL change_valid: got %b expected 0", bus.VALID); end
        compared++; if (bus.MASK !== 16'h8001) begin mismatched++; $display("[TB] FAIL change_mask: got %h expected 8001", bus.MASK); end
        runTracked(16'h8001, 0, 32, rise, errs);
        compared++; if (rise !== 32) begin mismatched++; $display("[TB] FAIL change_relock: got %0d expected 32", rise); end
        compared++; if (errs !== 0) begin mismatched++; $display("[TB] FAIL change_extra_err: got %0d expected 0", errs); end
    endtask

    task automatic test_enable_gap;
        logic [15:0] pat;
        int rise, errs;
        pat = 16'h8001;
        for (int s = 0; s < 6; s++) driveSlot(1'b1, s == 0, ~pat[s]);
        for (int k = 0; k < 5; k++) begin
            driveSlot(1'b0, k == 2, 1'b1);
            compared++; if (bus.SLOT !== 4'd6) begin mismatched++; $display("[TB] FAIL gap_slot: got %0d expected 6", bus.SLOT); end
            compared++; if (bus.ERR !== 1'b0 || bus.VALID !== 1'b1) begin mismatched++; $display("[TB] FAIL gap_flags: got err=%b valid=%b expected err=0 valid=1", bus.ERR, bus.VALID); end
        end
        runTracked(pat, 6, 26, rise, errs);
        compared++; if (errs !== 0) begin mismatched++; $display("[TB] FAIL gap_err_count: got %0d expected 0", errs); end
        compared++; if (bus.VALID !== 1'b1) begin mismatched++; $display("[TB] FAIL gap_valid: got %b expected 1", bus.VALID); end
        compared++; if (bus.MASK !== 16'h8001) begin mismatched++; $display("[TB] FAIL gap_mask: got %h expected 8001", bus.MASK); end
    endtask

    task automatic test_early_b0;
        logic [15:0] pat;
        int rise, errs;
        pat = 16'h0005;
        runTracked(pat, 0, 48, rise, errs);
        compared++; if (errs !== 1 || bus.VALID !== 1'b1 || bus.MASK !== 16'h0005) begin mismatched++; $display("[TB] FAIL early_setup: got errs=%0d valid=%b mask=%h expected 1/1/0005", errs, bus.VALID, bus.MASK); end
        for (int s = 0; s < 7; s++) driveSlot(1'b1, s == 0, ~pat[s]);
        compared++; if (bus.SLOT !== 4'd7) begin mismatched++; $display("[TB] FAIL early_slot7: got %0d expected 7", bus.SLOT); end
        driveSlot(1'b1, 1'b1, ~pat[0]);
        compared++; if (bus.ERR !== 1'b1) begin mismatched++; $display("[TB] FAIL early_err: got %b expected 1", bus.ERR); end
        compared++; if (bus.VALID !== 1'b0) begin mismatched++; $display("[TB] FAIL early_valid: got %b expected 0", bus.VALID); end
        compared++; if (bus.MASK !== 16'h0005) begin mismatched++; $display("[TB] FAIL early_mask: got %h expected 0005", bus.MASK); end
        compared++; if (bus.SLOT !== 4'd1) begin mismatched++; $display("[TB] FAIL early_slot: got %0d expected 1", bus.SLOT); end
        runTracked(pat, 1, 47, rise, errs);
        compared++; if (rise + 1 !== 48) begin mismatched++; $display("[TB] FAIL early_relock: got %0d expected 48", rise + 1); end
        compared++; if (errs !== 0) begin mismatched++; $display("[TB] FAIL early_extra_err: got %0d expected 0", errs); end
    endtask

    task automatic test_missing_b0;
        logic [15:0] pat;
        int rise, errs;
        pat = 16'h0005;
        driveSlot(1'b1, 1'b0, ~pat[0]);
        compared++; if (bus.ERR !== 1'b1) begin mismatched++; $display("[TB] FAIL miss_err: got %b expected 1", bus.ERR); end
        compared++; if (bus.VALID !== 1'b0) begin mismatched++; $display("[TB] FAIL miss_valid: got %b expected 0", bus.VALID); end
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            driveSlot(1'b1, 1'b0, (i % 3) == 0);
            if (bus.ERR === 1'b1) errs++;
        end
        compared++; if (errs !== 0) begin mismatched++; $display("[TB] FAIL hunt_err_count: got %0d expected 0", errs); end
        compared++; if (bus.MASK !== 16'h0005) begin mismatched++; $display("[TB] FAIL hunt_mask: got %h expected 0005", bus.MASK); end
        compared++; if (bus.SLOT !== 4'd5) begin mismatched++; $display("[TB] FAIL hunt_slot_run: got %0d expected 5", bus.SLOT); end
        runTracked(pat, 0, 48, rise, errs);
        compared++; if (rise !== 48 || errs !== 0) begin mismatched++; $display("[TB] FAIL hunt_relock: got rise=%0d errs=%0d expected 48/0", rise, errs); end
    endtask

    task automatic test_mid_reset;
        logic [15:0] pat;
        int rise, errs;
        pat = 16'h0005;
        for (int s = 0; s < 5; s++) driveSlot(1'b1, s == 0, ~pat[s]);
        RST = 1'b1;
        driveSlot(1'b1, 1'b0, 1'b1);
        RST = 1'b0;
        compared++; if (bus.MASK !== 16'h0000 || bus.VALID !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_mask_valid: got %h/%b expected 0000/0", bus.MASK, bus.VALID); end
        compared++; if (bus.ERR !== 1'b0 || bus.SLOT !== 4'd0) begin mismatched++; $display("[TB] FAIL midrst_err_slot: got %b/%0d expected 0/0", bus.ERR, bus.SLOT); end
        runTracked(pat, 0, 48, rise, errs);
        compared++; if (rise !== 48) begin mismatched++; $display("[TB] FAIL midrst_relock: got %0d expected 48", rise); end
        compared++; if (bus.MASK !== 16'h0005 || errs !== 0) begin mismatched++; $display("[TB] FAIL midrst_final: got mask=%h errs=%0d expected 0005/0", bus.MASK, errs); end
    endtask

    initial begin
        bus.E   = 1'b0;
        bus.B0  = 1'b0;
        bus.TOG = 1'b0;
        test_reset();
        test_lock();
        test_pattern_change();
        test_enable_gap();
        test_early_b0();
        test_missing_b0();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/skipdecode.md
# skipdecode

Receive-side decoder for the rotating clock-skip ring. It watches the delivered-pulse toggle from the gated clock domain and the ring's slot-0 marker. From these it rebuilds the LEN-bit skip mask one slot per enabled cycle, and asserts VALID once LOCK consecutive identical frames have been seen. It sits beside the skip ring in the fast clock domain and lets test logic and the monitor confirm that the programmed skip pattern is actually reaching the gated consumer.

## Interface
- LEN, 16: ring length in slots, i.e. the mask width; must be at least 2.
- LOCK, 3: number of consecutive identical frames needed before VALID asserts; must be at least 1.

- iCLK  in  1  ungated ring clock; all logic on posedge.
- RST  in  1  synchronous, active-high reset.
- E  in  1  ring enable; a cycle is a slot only when E=1.
- B0  in  1  slot-0 marker, high during slot 0 of each frame.
- TOG  in  1  level that toggles once per pulse delivered on the gated clock; sampled synchronously.
- MASK  out  LEN  decoded skip mask; bit i=1 means slot i was skipped.
- VALID  out  1  MASK is locked.
- ERR  out  1  one-cycle pulse on mismatch or framing error.
- SLOT  out  clog2(LEN)  index of the slot captured this cycle.

## Operation
- Pulse detection:
  - tog_q <= TOG every cycle, including during RST and E=0.
  - present = TOG ^ tog_q.
  - On an enabled slot, cap[SLOT] <= ~present.
- Slot counter:
  - SLOT advances by 1 on each E=1 cycle and wraps from LEN-1 to 0.
  - It holds on E=0.
  - It is forced to 1 on the next cycle after any E&B0 cycle.
- Frame word is cap with the bit for slot LEN-1 merged in. It completes on the E=1 cycle where SLOT==LEN-1.
- State machine, with cnt counting matching frames:
  - HUNT:
    - Ignore slots until an E&B0 cycle.
    - On that cycle capture slot 0 and go to FILL.
  - FILL: at frame end, MASK<=word and cnt<=1. Go to LOCKED if LOCK==1, otherwise CHECK.
  - CHECK: at frame end:
    - If word==MASK: cnt++, and go to LOCKED when the count reaches LOCK.
    - Otherwise: MASK<=word, cnt<=1, ERR pulse, stay in CHECK.
  - LOCKED:
    - VALID=1.
    - At frame end, if word!=MASK: MASK<=word, cnt<=1, ERR pulse, VALID<=0, go to CHECK. With LOCK==1, stay LOCKED instead.
- Framing errors, checked in every state except HUNT:
  - E&B0 with SLOT!=0:
    - ERR pulse and VALID<=0.
    - Discard the partial frame, treat this cycle as slot 0, go to FILL.
    - MASK holds its last value.
  - E=1, SLOT==0 and B0=0:
    - ERR pulse and VALID<=0.
    - Go to HUNT. MASK holds.
- Simultaneous events: a framing error takes priority over the frame-end compare. At most one ERR pulse per cycle.
- E=0 cycles are transparent: no capture, no counter change, no error. Toggles seen during them still update tog_q.

## Timing
- Reset values: MASK=0, VALID=0, ERR=0, SLOT=0, state=HUNT, cnt=0. tog_q loads TOG during reset.
- RST mid-operation: all of the above apply on the next edge, and any partial frame is discarded.
- Presence latency: zero. The toggle for slot k must be visible on TOG in the same cycle that E and SLOT identify as slot k.
- MASK, VALID and ERR all update on the edge that captures slot LEN-1 of a frame. They are registered outputs with no combinational path from inputs.
- With continuous E=1 and a stable pattern, VALID rises LOCK*LEN cycles after the first E&B0 cycle.
- ERR is high for exactly one cycle per event.

## Test plan
1. LEN=16, LOCK=3, pattern 0x0005, E=1 continuously, B0 every 16 cycles → VALID rises 48 cycles after the first B0; MASK=0x0005; no ERR.
2. While locked, change the pattern to 0x8001 → ERR for one cycle at the end of the first new frame, VALID=0, MASK=0x8001; VALID rises again 32 cycles later.
3. While locked, hold E=0 for 5 cycles mid-frame with gated pulses still toggling TOG → SLOT holds, no ERR, VALID stays 1, MASK unchanged.
4. While locked, assert B0 when SLOT=7 → one-cycle ERR, VALID=0, MASK holds 0x0005, SLOT=1 next cycle; VALID returns after 48 cycles.
5. While locked, drop B0 at the slot-0 cycle → ERR, state HUNT; no slots are captured until the next B0.
6. Assert RST for one cycle mid-frame while locked → next cycle MASK=0, VALID=0, ERR=0, SLOT=0; relock takes 48 cycles from the next B0.
